// File: rtl/multicycle_ctrl.sv
// Moore sequencing controller for the multi-cycle MIPS datapath: decodes the
// latched IR and drives per-state enables/selects, and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [2:0]       state,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RFWr,
  output logic             DMWr,
  output logic [1:0]       NPCop,
  output logic [1:0]       WRsel,
  output logic [1:0]       WDsel,
  output logic [2:0]       ALUop,
  output logic             Bsel,
  output logic             EXTop,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t cur_state, nxt_state;

  logic r_type, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal;

  assign r_type  = (opcode == 6'h00);
  assign is_addu = r_type && (funct == 6'h21);
  assign is_subu = r_type && (funct == 6'h23);
  assign is_jr   = r_type && (funct == 6'h08);
  assign is_ori  = (opcode == 6'h0d);
  assign is_lui  = (opcode == 6'h0f);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2b);
  assign is_beq  = (opcode == 6'h04);
  assign is_j    = (opcode == 6'h02);
  assign is_jal  = (opcode == 6'h03);

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_IF;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state  = S_IF;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RFWr       = 1'b0;
    DMWr       = 1'b0;
    NPCop      = 2'd0;
    WRsel      = 2'd0;
    WDsel      = 2'd0;
    ALUop      = 3'd0;
    Bsel       = 1'b0;
    EXTop      = 1'b0;
    instr_done = 1'b0;
    case (cur_state)
      S_IF: begin
        IRWr      = 1'b1;
        PCWr      = 1'b1;
        nxt_state = S_ID;
      end
      S_ID: begin
        // Jumps and nops finish here; everything else goes on to EX.
        if (is_j) begin
          PCWr = 1'b1; NPCop = 2'd2; instr_done = 1'b1;
        end else if (is_jal) begin
          PCWr = 1'b1; NPCop = 2'd2; RFWr = 1'b1;
          WRsel = 2'd2; WDsel = 2'd2; instr_done = 1'b1;
        end else if (is_jr) begin
          PCWr = 1'b1; NPCop = 2'd3; instr_done = 1'b1;
        end else if (is_addu || is_subu || is_ori || is_lui ||
                     is_lw || is_sw || is_beq) begin
          nxt_state = S_EX;
        end else begin
          instr_done = 1'b1;
        end
      end
      S_EX: begin
        nxt_state = S_WB;
        if (is_subu) begin
          ALUop = 3'd1;
        end else if (is_ori) begin
          ALUop = 3'd2; Bsel = 1'b1;
        end else if (is_lui) begin
          ALUop = 3'd3; Bsel = 1'b1;
        end else if (is_lw || is_sw) begin
          Bsel = 1'b1; EXTop = 1'b1; nxt_state = S_MEM;
        end else if (is_beq) begin
          ALUop = 3'd1; EXTop = 1'b1; NPCop = 2'd1;
          PCWr = zero; instr_done = 1'b1; nxt_state = S_IF;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          DMWr = 1'b1; instr_done = 1'b1;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_WB: begin
        RFWr       = 1'b1;
        instr_done = 1'b1;
        if (is_lw)       WDsel = 2'd1;
        else if (r_type) WRsel = 2'd1;
      end
      default: nxt_state = S_IF;
    endcase
    // Reset aborts the current instruction without any architectural write.
    if (reset) begin
      PCWr = 1'b0; IRWr = 1'b0; RFWr = 1'b0; DMWr = 1'b0; instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           retired <= '0;
    else if (instr_done) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model produces the
// expected per-cycle outputs and retired count for a 32-bit and a 3-bit counter.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic zero;

  logic [2:0] state_a, state_b;
  logic pcwr_a, irwr_a, rfwr_a, dmwr_a, bsel_a, ext_a, done_a;
  logic pcwr_b, irwr_b, rfwr_b, dmwr_b, bsel_b, ext_b, done_b;
  logic [1:0] npc_a, wrs_a, wds_a, npc_b, wrs_b, wds_b;
  logic [2:0] alu_a, alu_b;
  logic [31:0] ret_a;
  logic [2:0]  ret_b;

  int n_tests = 0;
  int n_fail  = 0;
  int retired_model = 0;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5,
                 K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_NOP = 10;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .state(state_a), .PCWr(pcwr_a), .IRWr(irwr_a), .RFWr(rfwr_a), .DMWr(dmwr_a),
    .NPCop(npc_a), .WRsel(wrs_a), .WDsel(wds_a), .ALUop(alu_a), .Bsel(bsel_a),
    .EXTop(ext_a), .instr_done(done_a), .retired(ret_a)
  );

  multicycle_ctrl #(.CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .state(state_b), .PCWr(pcwr_b), .IRWr(irwr_b), .RFWr(rfwr_b), .DMWr(dmwr_b),
    .NPCop(npc_b), .WRsel(wrs_b), .WDsel(wds_b), .ALUop(alu_b), .Bsel(bsel_b),
    .EXTop(ext_b), .instr_done(done_b), .retired(ret_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h21)      return K_ADDU;
        else if (fn == 6'h23) return K_SUBU;
        else if (fn == 6'h08) return K_JR;
        else                  return K_NOP;
      end
      6'h0d: return K_ORI;
      6'h0f: return K_LUI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  function automatic int latency(input int k);
    case (k)
      K_J, K_JAL, K_JR, K_NOP: return 2;
      K_BEQ:                   return 3;
      K_LW:                    return 5;
      default:                 return 4;
    endcase
  endfunction

  // Expected {state,PCWr,IRWr,RFWr,DMWr,NPCop,WRsel,WDsel,ALUop,Bsel,EXTop,done}
  // for cycle 'step' of an instruction of kind k.
  function automatic logic [18:0] model(input int k, input int step, input logic z);
    logic [2:0] st, alu;
    logic pc, ir, rf, dm, b, e, d;
    logic [1:0] np, wr, wd;
    {pc, ir, rf, dm, b, e, d} = '0;
    {np, wr, wd} = '0;
    alu = 3'd0;
    if (step < 3)       st = 3'(step);
    else if (step == 3) st = (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
    else                st = 3'd4;
    d = (step == latency(k) - 1);
    case (st)
      3'd0: begin pc = 1; ir = 1; end
      3'd1: begin
        if (k == K_J)   begin pc = 1; np = 2; end
        if (k == K_JAL) begin pc = 1; np = 2; rf = 1; wr = 2; wd = 2; end
        if (k == K_JR)  begin pc = 1; np = 3; end
      end
      3'd2: begin
        case (k)
          K_SUBU:      alu = 1;
          K_ORI:       begin alu = 2; b = 1; end
          K_LUI:       begin alu = 3; b = 1; end
          K_LW, K_SW:  begin b = 1; e = 1; end
          K_BEQ:       begin alu = 1; e = 1; np = 1; pc = z; end
          default: ;
        endcase
      end
      3'd3: dm = (k == K_SW);
      default: begin
        rf = 1;
        if (k == K_LW) wd = 1;
        else if (k == K_ADDU || k == K_SUBU) wr = 1;
      end
    endcase
    return {st, pc, ir, rf, dm, np, wr, wd, alu, b, e, d};
  endfunction

  function automatic logic [18:0] pack_a();
    return {state_a, pcwr_a, irwr_a, rfwr_a, dmwr_a, npc_a, wrs_a, wds_a,
            alu_a, bsel_a, ext_a, done_a};
  endfunction

  function automatic logic [18:0] pack_b();
    return {state_b, pcwr_b, irwr_b, rfwr_b, dmwr_b, npc_b, wrs_b, wds_b,
            alu_b, bsel_b, ext_b, done_b};
  endfunction

  task automatic check_retired();
    chk("retired32", 64'(ret_a), 64'(32'(retired_model)));
    chk("retired3", 64'(ret_b), 64'(retired_model % 8));
  endtask

  // Runs one instruction from IF; zmode<0 means random zero each cycle.
  // abort_step>=0 asserts reset in that cycle instead of completing.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int abort_step);
    int k;
    k = classify(op, fn);
    opcode = op;
    funct  = fn;
    for (int s = 0; s < latency(k); s++) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (s == abort_step) begin
        reset = 1'b1;
        #1;
        chk("abort_en", 64'({pcwr_a, irwr_a, rfwr_a, dmwr_a, done_a}), 64'd0);
        chk("abort_dmwr_b", 64'(dmwr_b), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        retired_model = 0;
        #1;
        chk("abort_state", 64'(state_a), 64'd0);
        check_retired();
        return;
      end
      #1;
      chk($sformatf("out_k%0d_s%0d", k, s), 64'(pack_a()), 64'(model(k, s, zero)));
      chk($sformatf("outb_k%0d_s%0d", k, s), 64'(pack_b()), 64'(model(k, s, zero)));
      check_retired();
      @(posedge clk); #1;
      if (s == latency(k) - 1) retired_model++;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      #1;
      chk("rst_en", 64'({pcwr_a, irwr_a, rfwr_a, dmwr_a, done_a}), 64'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    retired_model = 0;
    #1;
    chk("rst_out", 64'(pack_a()), 64'(model(K_NOP, 0, 1'b0)));
    check_retired();
  endtask

  initial begin
    logic [5:0] ops [11];
    logic [5:0] fns [4];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f};
    fns = '{6'h21, 6'h23, 6'h08, 6'h00};
    reset = 1'b1; opcode = 6'h0d; funct = 6'h00; zero = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    run_instr(6'h0d, 6'h00, -1, -1);   // ori
    run_instr(6'h23, 6'h00, -1, -1);   // lw
    run_instr(6'h04, 6'h00, 1, -1);    // beq taken
    run_instr(6'h04, 6'h00, 0, -1);    // beq not taken
    run_instr(6'h03, 6'h00, -1, -1);   // jal
    run_instr(6'h3f, 6'h00, -1, -1);   // unknown opcode
    run_instr(6'h00, 6'h00, -1, -1);   // op 0 unknown funct
    run_instr(6'h2b, 6'h00, -1, -1);   // sw
    run_instr(6'h0f, 6'h00, -1, -1);   // lui
    run_instr(6'h00, 6'h23, -1, -1);   // subu
    run_instr(6'h00, 6'h08, -1, -1);   // jr
    run_instr(6'h02, 6'h00, -1, -1);   // j
    run_instr(6'h2b, 6'h00, -1, 3);    // sw aborted in MEM

    do_reset(1);
    for (int i = 0; i < 9; i++) run_instr(6'h00, 6'h21, -1, -1);
    chk("wrap3", 64'(ret_b), 64'd1);

    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 10)];
      fn = fns[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      if ($urandom_range(0, 29) == 0)
        run_instr(op, fn, -1, $urandom_range(0, latency(classify(op, fn)) - 1));
      else
        run_instr(op, fn, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style sequencing controller for the multi-cycle MIPS datapath: shared PC/IR, GRF, ALU, DM and EXT are reused across the IF/ID/EX/MEM/WB states.
- Decodes the opcode and funct of the latched IR and emits per-state write enables and mux selects.
- Its select encodings match the single-cycle datapath selects, so the existing muxes and NPC are reused unchanged.
- Also counts retired instructions for the testbench and debug.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
opcode  in  6  IR[31:26], stable from the cycle after IF
funct  in  6  IR[5:0]
zero  in  1  ALU equality flag (in_1 == in_2)
state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4
PCWr  out  1  PC register load enable
IRWr  out  1  IR load enable
RFWr  out  1  GRF write enable
DMWr  out  1  DM store enable
NPCop  out  2  0 = PC+4, 1 = branch offset, 2 = imm26 jump, 3 = ra (GRF rs)
WRsel  out  2  0 = rt, 1 = rd, 2 = $31
WDsel  out  2  0 = ALU result register, 1 = DM data register, 2 = PC register (link)
ALUop  out  3  0 = add, 1 = sub, 2 = or, 3 = lui (imm << 16)
Bsel  out  1  ALU B input: 0 = rt data, 1 = imm32
EXTop  out  1  1 = sign-extend, 0 = zero-extend
instr_done  out  1  high in the final cycle of each instruction
retired  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset: in a cycle with reset=1, all enables (PCWr, IRWr, RFWr, DMWr) and instr_done are forced 0. Next state is IF and retired is cleared to 0. Reset mid-instruction aborts it with no architectural write.
- After reset, state=0 and all selects are 0.
- Decoded instructions:
  - addu: op 0, funct 0x21.
  - subu: op 0, funct 0x23.
  - jr: op 0, funct 0x08.
  - ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, j 0x02, jal 0x03.
- Any other opcode, or op 0 with any other funct, is a nop.
- Outputs are combinational from state, opcode, funct and zero. State and retired update on the rising edge.
- IF: IRWr=1, PCWr=1, NPCop=0. Next state is ID. After IF the PC register holds PC+4.
- ID:
  - j: PCWr=1, NPCop=2, done; next IF.
  - jal: PCWr=1, NPCop=2, RFWr=1, WRsel=2, WDsel=2 (writes the old PC+4), done; next IF.
  - jr: PCWr=1, NPCop=3, done; next IF.
  - nop: done; next IF.
  - All others: next EX.
- EX:
  - addu/subu: ALUop 0 or 1, Bsel=0; next WB.
  - ori: ALUop=2, Bsel=1, EXTop=0; next WB.
  - lui: ALUop=3, Bsel=1; next WB.
  - lw/sw: ALUop=0, Bsel=1, EXTop=1; next MEM.
  - beq: ALUop=1, Bsel=0, EXTop=1, NPCop=1, PCWr=zero, done; next IF. The offset is relative to the PC register (already +4).
- MEM:
  - sw: DMWr=1, done; next IF.
  - lw: next WB.
- WB: RFWr=1.
  - R-type: WRsel=1, WDsel=0.
  - ori/lui: WRsel=0, WDsel=0.
  - lw: WRsel=0, WDsel=1.
  - done; next IF.
- Latency in cycles: j/jal/jr/nop 2, beq 3, sw 4, addu/subu/ori/lui 4, lw 5.
- Default values: every enable not listed for a state is 0 and every select not listed is 0.
- States 5..7 are illegal. They decode as no-op with all enables 0, and the next state is IF.
- retired increments on each edge where instr_done=1 and reset=0. It wraps from 2^CNT_W-1 to 0.

Test Plan:
- reset held 2 cycles, then released with opcode=0x0d -> state sequence 0,1,2,4,0. RFWr=1 only in state 4 with WRsel=0, WDsel=0. retired goes 0 -> 1.
- lw (0x23) -> states 0,1,2,3,4, with DMWr=0 throughout. In WB: RFWr=1, WDsel=1. Latency is 5 cycles.
- beq with zero=1 in EX, then beq with zero=0 -> PCWr=1 with NPCop=1 in the first case and PCWr=0 in the second. Both return to IF after 3 cycles.
- jal (0x03) -> in ID: PCWr=1, NPCop=2, RFWr=1, WRsel=2, WDsel=2, instr_done=1. Then IF.
- Unknown opcode 0x3f, and op 0 with funct 0x00 -> 2-cycle nop with no RFWr/DMWr. retired still increments.
- reset asserted in MEM of sw -> DMWr=0 that cycle, next state IF, retired=0.
- CNT_W=3, run 9 addu -> retired reads 1 (wrapped).
